// File: rtl/mp2_cpu.sv
// mp2_cpu: multicycle RV32I core (no FENCE/ECALL/CSR) with a single
// request/response memory port. Every instruction is fetched through MAR/MDR
// into IR, decoded, and then either executed in one cycle or sent down the
// load or store path. PC is written exactly once per instruction, at its end.
module mp2_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_EXEC,
    S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2
  } state_t;

  state_t state, state_next;

  logic [31:0] pc, mar, mdr, ir;
  logic [31:0] regs [32];

  // Instruction fields and immediates
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign funct7_5 = ir[30];

  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign u_imm = {ir[31:12], 12'b0};
  assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // x0 always reads as zero
  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc + 32'd4;

  logic load_ok, store_ok;
  assign load_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign store_ok = funct3 inside {3'b000, 3'b001, 3'b010};

  // Byte lane of the current data access; drives both store and load shifting
  logic [4:0] lane_shift;
  assign lane_shift = {mar[1:0], 3'b000};

  // ALU shared by OP-IMM and OP; SUB only exists for register-register ops
  logic [31:0] alu_b, alu_out;
  assign alu_b = (opcode == OPC_OP) ? rs2_val : i_imm;

  // Arithmetic/logic result for the current instruction
  always_comb begin
    // NOTE: every path assigns a default first so no latch is inferred.
    alu_out = '0;
    case (funct3)
      3'b000: alu_out = (opcode == OPC_OP && funct7_5) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001: alu_out = rs1_val << alu_b[4:0];
      3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_out = {31'd0, rs1_val < alu_b};
      3'b100: alu_out = rs1_val ^ alu_b;
      3'b101: alu_out = funct7_5 ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'b110: alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  // Branch condition; undefined funct3 values never take the branch
  logic branch_taken;
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000: branch_taken = (rs1_val == rs2_val);
      3'b001: branch_taken = (rs1_val != rs2_val);
      3'b100: branch_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101: branch_taken = !($signed(rs1_val) < $signed(rs2_val));
      3'b110: branch_taken = (rs1_val < rs2_val);
      3'b111: branch_taken = !(rs1_val < rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  // Load data: align the addressed byte/halfword to bit 0, then extend
  logic [31:0] load_shifted, load_data;
  assign load_shifted = mdr >> lane_shift;
  always_comb begin
    load_data = load_shifted;
    case (funct3)
      3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_data = {24'd0, load_shifted[7:0]};
      3'b101:  load_data = {16'd0, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
  end

  // Store lanes: shifted into place and truncated, misaligned accesses are not split
  logic [3:0] store_be;
  always_comb begin
    store_be = 4'b1111;
    case (funct3[1:0])
      2'b00:   store_be = 4'b0001 << mar[1:0];
      2'b01:   store_be = 4'b0011 << mar[1:0];
      default: store_be = 4'b1111;
    endcase
  end

  // MAR, IR and the register file hold still during ST1, so these stay stable
  assign mem_address     = {mar[31:2], 2'b00};
  assign mem_wdata       = rs2_val << lane_shift;
  assign mem_byte_enable = (state == S_ST1) ? store_be : 4'b1111;

  logic        pc_we, mar_we, mdr_we, ir_we, rd_we;
  logic [31:0] pc_next, mar_next, rd_wdata;

  // Control: next state, memory handshake and write enables
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pc_we      = 1'b0;
    pc_next    = pc_plus4;
    mar_we     = 1'b0;
    mar_next   = pc;
    mdr_we     = 1'b0;
    ir_we      = 1'b0;
    rd_we      = 1'b0;
    rd_wdata   = alu_out;
    case (state)
      S_FETCH1: begin
        mar_we     = 1'b1;
        mar_next   = pc;
        state_next = S_FETCH2;
      end
      S_FETCH2: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          mdr_we     = 1'b1;
          state_next = S_FETCH3;
        end
      end
      S_FETCH3: begin
        ir_we      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if ((opcode == OPC_LOAD && load_ok) || (opcode == OPC_STORE && store_ok))
          state_next = S_CALC_ADDR;
        else
          state_next = S_EXEC;
      end
      S_EXEC: begin
        pc_we      = 1'b1;
        state_next = S_FETCH1;
        case (opcode)
          OPC_IMM, OPC_OP: begin
            rd_we    = 1'b1;
            rd_wdata = alu_out;
          end
          OPC_LUI: begin
            rd_we    = 1'b1;
            rd_wdata = u_imm;
          end
          OPC_AUIPC: begin
            rd_we    = 1'b1;
            rd_wdata = pc + u_imm;
          end
          OPC_BRANCH: begin
            if (branch_taken) pc_next = pc + b_imm;
          end
          OPC_JAL: begin
            rd_we    = 1'b1;
            rd_wdata = pc_plus4;
            pc_next  = pc + j_imm;
          end
          OPC_JALR: begin
            // Target uses rs1 as read this cycle, before rd is overwritten
            if (funct3 == 3'b000) begin
              rd_we    = 1'b1;
              rd_wdata = pc_plus4;
              pc_next  = (rs1_val + i_imm) & ~32'd1;
            end
          end
          default: ;
        endcase
      end
      S_CALC_ADDR: begin
        mar_we     = 1'b1;
        mar_next   = rs1_val + ((opcode == OPC_STORE) ? s_imm : i_imm);
        state_next = (opcode == OPC_STORE) ? S_ST1 : S_LD1;
      end
      S_LD1: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          mdr_we     = 1'b1;
          state_next = S_LD2;
        end
      end
      S_LD2: begin
        rd_we      = 1'b1;
        rd_wdata   = load_data;
        pc_we      = 1'b1;
        state_next = S_FETCH1;
      end
      S_ST1: begin
        mem_write = 1'b1;
        if (mem_resp) state_next = S_ST2;
      end
      S_ST2: begin
        pc_we      = 1'b1;
        state_next = S_FETCH1;
      end
      default: state_next = S_FETCH1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) state <= S_FETCH1;
    else      state <= state_next;
  end

  // Architectural and staging registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= RESET_PC;
      mar <= '0;
      mdr <= '0;
      ir  <= '0;
    end else begin
      if (pc_we)  pc  <= pc_next;
      if (mar_we) mar <= mar_next;
      if (mdr_we) mdr <= mem_rdata;
      if (ir_we)  ir  <= mdr;
    end
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the register file must read zero after reset, so the array is
    // reset explicitly; this keeps it in flops rather than a RAM macro.
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rd_we && rd != 5'd0) begin
      regs[rd] <= rd_wdata;
    end
  end

endmodule

// File: tb/tb_mp2_cpu.sv
// tb_mp2_cpu: builds a partly directed, partly random RV32I program, runs it
// through an instruction-level reference model to get the expected sequence of
// memory transactions, then serves the DUT's bus with random latency and
// compares every request against that sequence.
module tb_mp2_cpu;

  logic        clk;
  logic        rst;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;

  mp2_cpu dut (
    .clk             (clk),
    .rst             (rst),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic [31:0] dut_mem [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] rf [32];
  logic [31:0] ipc;
  logic [31:0] epc;
  logic [31:0] halt_pc;
  txn_t        exp_q [$];
  int          sb_idx = -1;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm20, input logic [4:0] rd, input logic [6:0] op);
    return {imm20, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic emit(input logic [31:0] ins);
    dut_mem[epc[13:2]] = ins;
    ref_mem[epc[13:2]] = ins;
    epc = epc + 32'd4;
  endtask

  // ---------------- program construction ----------------
  task automatic build_program();
    logic [31:0] v, hi, imm, ins;
    logic [4:0]  rd, ra, rb;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          kind, off;
    for (int i = 0; i < 4096; i++) begin dut_mem[i] = '0; ref_mem[i] = '0; end
    for (int i = 32'h600 >> 2; i < (32'h800 >> 2); i++) begin
      v = $urandom; dut_mem[i] = v; ref_mem[i] = v;
    end
    dut_mem[32'h1000 >> 2] = 32'h0080_0000;
    ref_mem[32'h1000 >> 2] = 32'h0080_0000;

    epc = 32'h60;
    emit(enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13));        // 60 ADDI x1,x0,5
    emit(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2, 7'h33));  // 64 ADD  x2,x1,x1
    emit(enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd3, 7'h33));  // 68 SUB  x3,x0,x1
    emit(enc_u(20'd1, 5'd5, 7'h37));                    // 6C LUI  x5,1
    emit(enc_i(32'd3, 5'd5, 3'd0, 5'd5, 7'h13));        // 70 ADDI x5,x5,3
    emit(enc_i(32'hAB, 5'd0, 3'd0, 5'd6, 7'h13));       // 74 ADDI x6,x0,0xAB
    emit(enc_i(32'h200, 5'd0, 3'd0, 5'd8, 7'h13));      // 78 ADDI x8,x0,0x200
    emit(enc_s(32'd0, 5'd6, 5'd5, 3'd0));               // 7C SB   x6,0(x5)
    emit(enc_i(32'd1, 5'd8, 3'd0, 5'd1, 7'h67));        // 80 JALR x1,1(x8)
    emit(enc_i(32'd1, 5'd0, 3'd0, 5'd10, 7'h13));       // 84 skipped

    epc = 32'h200;
    emit(enc_i(32'hFFFF_FFFF, 5'd5, 3'd0, 5'd7, 7'h03));   // LB  x7,-1(x5)
    emit(enc_i(32'hFFFF_FFFF, 5'd5, 3'd4, 5'd11, 7'h03));  // LBU x11,-1(x5)
    emit(enc_s(32'h500, 5'd2, 5'd0, 3'd2));
    emit(enc_s(32'h504, 5'd3, 5'd0, 3'd2));
    emit(enc_s(32'h508, 5'd7, 5'd0, 3'd2));
    emit(enc_s(32'h50C, 5'd11, 5'd0, 3'd2));
    emit(enc_s(32'h510, 5'd1, 5'd0, 3'd2));

    for (int r = 1; r < 16; r++) begin
      v  = $urandom;
      hi = (v + 32'h800) >> 12;
      emit(enc_u(hi[19:0], 5'(r), 7'h37));
      emit(enc_i(v, 5'(r), 3'd0, 5'(r), 7'h13));
    end

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      rd = 5'($urandom_range(0, 15));
      ra = 5'($urandom_range(0, 15));
      rb = 5'($urandom_range(0, 15));
      f3 = 3'($urandom_range(0, 7));
      imm = $urandom;
      case (kind)
        0, 9: begin
          if (f3 == 3'd1) imm = {27'd0, imm[4:0]};
          else if (f3 == 3'd5) imm = {21'd0, imm[10], 5'd0, imm[4:0]};
          emit(enc_i(imm, ra, f3, rd, 7'h13));
        end
        1, 2: begin
          f7 = ((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 7'h20 : 7'h00;
          emit(enc_r(f7, rb, ra, f3, rd, 7'h33));
        end
        3: emit(enc_u(imm[19:0], rd, imm[31] ? 7'h37 : 7'h17));
        4: begin
          if (f3 == 3'd3) f3 = 3'd0;
          emit(enc_b(32'd8, rb, ra, f3));
        end
        5: emit(enc_j(32'd8, rd));
        6: begin
          case ($urandom_range(0, 5))
            0: begin f3 = 3'd0; off = $urandom_range(0, 3); end
            1: begin f3 = 3'd4; off = $urandom_range(0, 3); end
            2: begin f3 = 3'd1; off = $urandom_range(0, 2); end
            3: begin f3 = 3'd5; off = $urandom_range(0, 2); end
            4: begin f3 = 3'd2; off = 0; end
            default: begin f3 = 3'd3; off = 0; end
          endcase
          emit(enc_i(32'h600 + 4 * $urandom_range(0, 127) + off, 5'd0, f3, rd, 7'h03));
        end
        7: begin
          case ($urandom_range(0, 3))
            0: begin f3 = 3'd0; off = $urandom_range(0, 3); end
            1: begin f3 = 3'd1; off = $urandom_range(0, 2); end
            2: begin f3 = 3'd2; off = 0; end
            default: begin f3 = 3'd3; off = 0; end
          endcase
          emit(enc_s(32'h600 + 4 * $urandom_range(0, 127) + off, rb, 5'd0, f3));
        end
        default: begin
          case ($urandom_range(0, 2))
            0: ins = {imm[31:7], 7'h0B};
            1: ins = 32'h0000_000F;
            default: ins = 32'h0000_0073;
          endcase
          emit(ins);
        end
      endcase
    end

    for (int r = 1; r < 16; r++) emit(enc_s(32'h580 + 4 * r, 5'(r), 5'd0, 3'd2));
    emit(enc_b(32'd0, 5'd0, 5'd0, 3'd0));   // BEQ x0,x0,0: halt loop
  endtask

  // ---------------- instruction-level reference model ----------------
  task automatic iss_step(output bit halted);
    logic [31:0] ins, a, b, res, addr, word, nxt, data;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [3:0]  be;
    bit          wr, taken;
    int          sh;
    ins = ref_mem[ipc[13:2]];
    exp_q.push_back('{we: 1'b0, addr: ipc, be: 4'hF, wdata: 32'h0});
    op = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7];
    a = rf[ins[19:15]]; b = rf[ins[24:20]];
    nxt = ipc + 4; wr = 0; res = 0;
    case (op)
      7'h13, 7'h33: begin
        if (op == 7'h13) b = {{20{ins[31]}}, ins[31:20]};
        case (f3)
          3'd0: res = (op == 7'h33 && ins[30]) ? a - b : a + b;
          3'd1: res = a << b[4:0];
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: res = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: res = a | b;
          default: res = a & b;
        endcase
        wr = 1;
      end
      7'h37: begin res = {ins[31:12], 12'd0}; wr = 1; end
      7'h17: begin res = ipc + {ins[31:12], 12'd0}; wr = 1; end
      7'h6F: begin
        res = ipc + 4; wr = 1;
        nxt = ipc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h67: if (f3 == 3'd0) begin
        res = ipc + 4; wr = 1;
        nxt = (a + {{20{ins[31]}}, ins[31:20]}) & 32'hFFFF_FFFE;
      end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = $signed(a) < $signed(b);
          3'd5: taken = $signed(a) >= $signed(b);
          3'd6: taken = a < b;
          3'd7: taken = a >= b;
          default: taken = 0;
        endcase
        if (taken) nxt = ipc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        addr = a + {{20{ins[31]}}, ins[31:20]};
        exp_q.push_back('{we: 1'b0, addr: {addr[31:2], 2'b00}, be: 4'hF, wdata: 32'h0});
        word = ref_mem[addr[13:2]];
        sh = 8 * int'(addr[1:0]);
        res = word >> sh;
        case (f3)
          3'd0: begin res = res & 32'hFF;   if (res >= 128)   res = res - 256; end
          3'd1: begin res = res & 32'hFFFF; if (res >= 32768) res = res - 65536; end
          3'd4: res = res & 32'hFF;
          3'd5: res = res & 32'hFFFF;
          default: ;
        endcase
        wr = 1;
      end
      7'h23: if (f3 <= 3'd2) begin
        addr = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
        sh = 8 * int'(addr[1:0]);
        data = b << sh;
        be = (f3 == 3'd0) ? 4'(1 << addr[1:0]) : (f3 == 3'd1) ? 4'(3 << addr[1:0]) : 4'hF;
        if (ipc == 32'h7C) sb_idx = exp_q.size();
        exp_q.push_back('{we: 1'b1, addr: {addr[31:2], 2'b00}, be: be, wdata: data});
        for (int l = 0; l < 4; l++)
          if (be[l]) ref_mem[addr[13:2]][8*l +: 8] = data[8*l +: 8];
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) rf[rd] = res;
    halted = (nxt == ipc);
    ipc = nxt;
  endtask

  // ---------------- bus helpers ----------------
  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (mem_read || mem_write) ok = 1;
      else @(negedge clk);
    end
  endtask

  // Holds the request for lat cycles, checks it stays put, then completes it
  task automatic serve(input int lat, input string tag);
    logic [69:0] snap;
    int unstable;
    unstable = 0;
    snap = {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata};
    for (int k = 0; k < lat; k++) begin
      mem_rdata = $urandom;
      @(negedge clk);
      if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} !== snap) unstable++;
    end
    check({tag, "_stable"}, unstable, 0);
    if (mem_write) begin
      for (int l = 0; l < 4; l++)
        if (mem_byte_enable[l]) dut_mem[mem_address[13:2]][8*l +: 8] = mem_wdata[8*l +: 8];
      mem_rdata = $urandom;
    end else begin
      mem_rdata = dut_mem[mem_address[13:2]];
    end
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit   ok, halted;
    int   cyc, diff;
    txn_t e;
    string tag;

    rst = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
    build_program();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    ipc = 32'h60;
    halted = 0;
    for (int s = 0; s < 2000 && !halted; s++) iss_step(halted);
    halt_pc = ipc;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_byte_enable", mem_byte_enable, 4'hF);

    // First fetch after release
    rst = 1'b1;
    cyc = 0;
    @(negedge clk); cyc++;
    while (!mem_read && cyc < 10) begin @(negedge clk); cyc++; end
    check("first_fetch_latency", cyc, 1);
    check("first_fetch_addr", mem_address, 32'h60);

    // Reset in the middle of a fetch abandons it; a stray resp in FETCH1 is ignored
    rst = 1'b0;
    #1;
    check("abort_mem_read", mem_read, 0);
    check("abort_byte_enable", mem_byte_enable, 4'hF);
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;

    // Lockstep against the reference transaction list
    for (int t = 0; t < exp_q.size() && n_bad < 20; t++) begin
      tag = $sformatf("txn%0d", t);
      wait_req(ok);
      check({tag, "_seen"}, ok, 1);
      if (!ok) break;
      e = exp_q[t];
      check({tag, "_kind"}, {mem_write, mem_read}, {e.we, ~e.we});
      check({tag, "_addr"}, mem_address, e.addr);
      check({tag, "_be"}, mem_byte_enable, e.be);
      if (e.we) check({tag, "_wdata"}, mem_wdata, e.wdata);
      if (t == sb_idx) begin
        check("sb_addr", mem_address, 32'h1000);
        check("sb_be", mem_byte_enable, 4'b1000);
        check("sb_wdata", mem_wdata, 32'hAB00_0000);
      end
      serve((t == 0) ? 7 : $urandom_range(0, 3), tag);
    end

    // Branch-to-self keeps refetching the same instruction
    for (int h = 0; h < 3; h++) begin
      wait_req(ok);
      check("halt_seen", ok, 1);
      if (!ok) break;
      check("halt_fetch_read", mem_read, 1);
      check("halt_fetch_addr", mem_address, halt_pc);
      serve(1, "halt");
    end

    // Directed results dumped by the program
    check("x2_add", dut_mem[32'h500 >> 2], 32'd10);
    check("x3_sub", dut_mem[32'h504 >> 2], 32'hFFFF_FFFB);
    check("x7_lb", dut_mem[32'h508 >> 2], 32'hFFFF_FF80);
    check("x11_lbu", dut_mem[32'h50C >> 2], 32'h0000_0080);
    check("x1_jalr_link", dut_mem[32'h510 >> 2], 32'h0000_0084);
    check("sb_word", dut_mem[32'h1000 >> 2], 32'hAB80_0000);

    diff = 0;
    for (int i = 0; i < 4096; i++) if (dut_mem[i] !== ref_mem[i]) diff++;
    check("mem_image_diffs", diff, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
